// File: rtl/fmul_result_stage.sv
// -----------------------------------------------------------------------------
// fmul_result_stage
//
// This is the registered result stage that sits after the combinational 32-bit
// Vedic float multiplier. The stage receives each operand pair together with
// the multiplier's raw packed output. It replaces that output wherever the
// multiplier gives a wrong answer: NaN, infinity, zero/denormal operands, and
// exponent overflow/underflow. Corrected results go into a 2-entry FIFO that
// drains through a valid/ready handshake. The stage does no rounding, so any
// mantissa truncation done by the multiplier is passed through as-is.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset (clears FIFO and outputs)
//   in_valid    op_a/op_b/mul_o are valid this cycle
//   in_ready    stage can accept a pair (count < 2, registered only)
//   op_a, op_b  IEEE-754 single operands, the same ones fed to the multiplier
//   mul_o       raw multiplier output for op_a * op_b
//   out_valid   FIFO head is valid
//   out_ready   consumer takes the head this cycle
//   out_result  corrected product at the FIFO head
//   out_flags   {invalid, overflow, underflow, zero} for the head entry
// -----------------------------------------------------------------------------
module fmul_result_stage #(
   parameter int MSB  = 31,
   parameter int BIAS = 127
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [MSB:0]   op_a,
   input  logic [MSB:0]   op_b,
   input  logic [MSB:0]   mul_o,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [MSB:0]   out_result,
   output logic [3:0]     out_flags
);

   localparam int ENTRY_W = MSB + 1 + 4;

   // ---------------------------------------------------------------
   // Field decode
   // ---------------------------------------------------------------
   logic        a_sign, b_sign, res_sign;
   logic [7:0]  a_exp, b_exp;
   logic [22:0] a_man, b_man;
   logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

   assign a_sign   = op_a[MSB];
   assign b_sign   = op_b[MSB];
   assign a_exp    = op_a[30:23];
   assign b_exp    = op_b[30:23];
   assign a_man    = op_a[22:0];
   assign b_man    = op_b[22:0];
   assign res_sign = a_sign ^ b_sign;

   assign a_nan  = (a_exp == 8'hFF) && (a_man != 23'd0);
   assign b_nan  = (b_exp == 8'hFF) && (b_man != 23'd0);
   assign a_inf  = (a_exp == 8'hFF) && (a_man == 23'd0);
   assign b_inf  = (b_exp == 8'hFF) && (b_man == 23'd0);
   // A denormal operand is flushed to zero, so only the exponent is checked.
   assign a_zero = (a_exp == 8'h00);
   assign b_zero = (b_exp == 8'h00);

   // The multiplier sign is recomputed from the operands, so mul_o's sign bit
   // is deliberately ignored.
   logic mul_sign_unused;
   assign mul_sign_unused = mul_o[MSB];

   // ---------------------------------------------------------------
   // Exponent reconstruction
   // When the mantissa product normalises, the multiplier bumps its exponent
   // field by one, to eA+eB-126. Comparing that field (mod 256) tells us
   // whether normalisation happened, without re-doing the mantissa product.
   // ---------------------------------------------------------------
   logic [7:0]        norm_ref;
   logic              norm;
   logic [9:0]        exp_sum;
   logic signed [9:0] true_exp;

   assign norm_ref = a_exp + b_exp - 8'd126;
   assign norm     = (mul_o[30:23] == norm_ref);
   assign exp_sum  = {2'b00, a_exp} + {2'b00, b_exp};
   // The 10-bit signed range (-512..511) holds every reachable value (-127..384).
   assign true_exp = $signed(exp_sum - 10'(BIAS) + {9'd0, norm});

   // ---------------------------------------------------------------
   // Classification (priority order, first match wins)
   // ---------------------------------------------------------------
   logic [MSB:0] new_result;
   logic [3:0]   new_flags;

   always_comb begin
      new_result = {res_sign, mul_o[30:0]};
      new_flags  = 4'b0000;
      if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
         new_result = 32'h7FC0_0000;
         new_flags  = 4'b1000;
      end else if (a_inf || b_inf) begin
         new_result = {res_sign, 8'hFF, 23'd0};
         new_flags  = 4'b0000;
      end else if (a_zero || b_zero) begin
         new_result = {res_sign, 31'd0};
         new_flags  = 4'b0001;
      end else if (true_exp >= 10'sd255) begin
         new_result = {res_sign, 8'hFF, 23'd0};
         new_flags  = 4'b0100;
      end else if (true_exp <= 10'sd0) begin
         new_result = {res_sign, 31'd0};
         new_flags  = 4'b0011;
      end
   end

   // ---------------------------------------------------------------
   // 2-entry FIFO
   // ---------------------------------------------------------------
   logic [ENTRY_W-1:0] entry_q [2];
   logic [ENTRY_W-1:0] entry_d [2];
   logic               wr_ptr_q, wr_ptr_d;
   logic               rd_ptr_q, rd_ptr_d;
   logic [1:0]         count_q, count_d;
   logic               push, pop;
   logic [ENTRY_W-1:0] head;

   // in_ready depends only on registered count. A full FIFO therefore
   // refuses a push even if a pop happens in the same cycle.
   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      entry_d  = entry_q;
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      count_d  = count_q;
      if (push) begin
         entry_d[wr_ptr_q] = {new_result, new_flags};
      end
      if (push && !pop) begin
         count_d = count_q + 2'd1;
      end else if (pop && !push) begin
         count_d = count_q - 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // Clearing the storage means the outputs read zero after reset and
         // no stale result can reappear.
         for (int i = 0; i < 2; i++) begin
            entry_q[i] <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         entry_q  <= entry_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // The head is read straight from the storage registers. While empty, no
   // write targets the slot at rd_ptr without also making out_valid high, so
   // the outputs stay stable.
   assign head       = entry_q[rd_ptr_q];
   assign out_result = head[ENTRY_W-1:4];
   assign out_flags  = head[3:0];

endmodule

// File: tb/tb_fmul_result_stage.sv
// -----------------------------------------------------------------------------
// tb_fmul_result_stage
//
// Directed testbench for fmul_result_stage. Inputs are driven on the falling
// edge and outputs are sampled on the falling edge, so every check happens
// half a cycle after the rising edge it depends on.
// -----------------------------------------------------------------------------
module tb_fmul_result_stage;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [31:0] mul_o;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [3:0]  out_flags;

   int total;
   int bad;

   fmul_result_stage #(.MSB(31), .BIAS(127)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op_a       (op_a),
      .op_b       (op_b),
      .mul_o      (mul_o),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Payload for the FIFO tests: 1.0 x 1.0 gives a normal result (E = 127,
   // with norm = 0 because the exponent field 0x7F is not 0x80). The result
   // is therefore mul_o itself, tagged with a distinct mantissa k.
   function automatic logic [31:0] tag(input int k);
      return 32'h3F80_0000 | 32'(k);
   endfunction

   task automatic drive_tag(input int k);
      in_valid = 1'b1;
      op_a     = 32'h3F80_0000;
      op_b     = 32'h3F80_0000;
      mul_o    = tag(k);
   endtask

   // ---------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      op_a = '0; op_b = '0; mul_o = '0;
      #12;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_handshake: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
      end
      total++;
      if (out_result !== 32'h0 || out_flags !== 4'h0) begin
         bad++;
         $display("FAIL reset_outputs: result=%h flags=%b expected 00000000/0000", out_result, out_flags);
      end
      // Release at a falling edge and offer a pair at once. It must be
      // accepted on the very next rising edge.
      @(negedge clk);
      rst = 1'b0;
      drive_tag(1);
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_result !== tag(1)) begin
         bad++;
         $display("FAIL first_push_after_reset: valid=%b result=%h expected 1/%h", out_valid, out_result, tag(1));
      end
      $display("reset: first push after release -> valid=%b result=%h", out_valid, out_result);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   // ---------------------------------------------------------------
   task automatic test_classify();
      logic [31:0] va [14];
      logic [31:0] vb [14];
      logic [31:0] vm [14];
      logic [31:0] vr [14];
      logic [3:0]  vf [14];
      // normal 2.0 x 3.0
      va[0]  = 32'h4000_0000; vb[0]  = 32'h4040_0000; vm[0]  = 32'h40C0_0000; vr[0]  = 32'h40C0_0000; vf[0]  = 4'b0000;
      // inf x zero
      va[1]  = 32'h7F80_0000; vb[1]  = 32'h0000_0000; vm[1]  = 32'h0000_0000; vr[1]  = 32'h7FC0_0000; vf[1]  = 4'b1000;
      // -inf x 1.0
      va[2]  = 32'hFF80_0000; vb[2]  = 32'h3F80_0000; vm[2]  = 32'h0000_0000; vr[2]  = 32'hFF80_0000; vf[2]  = 4'b0000;
      // -0 x 2.0
      va[3]  = 32'h8000_0000; vb[3]  = 32'h4000_0000; vm[3]  = 32'h0000_0000; vr[3]  = 32'h8000_0000; vf[3]  = 4'b0001;
      // overflow: the real multiplier gives exponent field 381 mod 256 = 0x7D
      va[4]  = 32'h7F00_0000; vb[4]  = 32'h7F00_0000; vm[4]  = 32'h3E80_0000; vr[4]  = 32'h7F80_0000; vf[4]  = 4'b0100;
      // underflow: exponent field -125 mod 256 = 0x83
      va[5]  = 32'h0080_0000; vb[5]  = 32'h0080_0000; vm[5]  = 32'h4180_0000; vr[5]  = 32'h0000_0000; vf[5]  = 4'b0011;
      // zero x inf
      va[6]  = 32'h0000_0000; vb[6]  = 32'h7F80_0000; vm[6]  = 32'h0000_0000; vr[6]  = 32'h7FC0_0000; vf[6]  = 4'b1000;
      // NaN operand
      va[7]  = 32'h7FC0_0001; vb[7]  = 32'h3F80_0000; vm[7]  = 32'h0000_0000; vr[7]  = 32'h7FC0_0000; vf[7]  = 4'b1000;
      // E exactly 255 (128 + 254 - 127, norm 0)
      va[8]  = 32'h4000_0000; vb[8]  = 32'h7F00_0000; vm[8]  = 32'h7F80_0000; vr[8]  = 32'h7F80_0000; vf[8]  = 4'b0100;
      // E exactly 0 (63 + 64 - 127, norm 0)
      va[9]  = 32'h1F80_0000; vb[9]  = 32'h2000_0000; vm[9]  = 32'h0000_0000; vr[9]  = 32'h0000_0000; vf[9]  = 4'b0011;
      // same operands, norm 1 lifts E to 1 -> normal pass-through
      va[10] = 32'h1F80_0000; vb[10] = 32'h2000_0000; vm[10] = 32'h0081_2345; vr[10] = 32'h0081_2345; vf[10] = 4'b0000;
      // negative normal -2.0 x 3.0
      va[11] = 32'hC000_0000; vb[11] = 32'h4040_0000; vm[11] = 32'hC0C0_0000; vr[11] = 32'hC0C0_0000; vf[11] = 4'b0000;
      // inf x -inf
      va[12] = 32'h7F80_0000; vb[12] = 32'hFF80_0000; vm[12] = 32'h0000_0000; vr[12] = 32'hFF80_0000; vf[12] = 4'b0000;
      // denormal x 2.0 -> flushed to zero
      va[13] = 32'h0000_0001; vb[13] = 32'h4000_0000; vm[13] = 32'h0000_0000; vr[13] = 32'h0000_0000; vf[13] = 4'b0001;

      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         in_valid = 1'b1; out_ready = 1'b0;
         op_a = va[i]; op_b = vb[i]; mul_o = vm[i];
         @(negedge clk);
         in_valid = 1'b0;
         total++;
         if (out_valid !== 1'b1 || out_result !== vr[i] || out_flags !== vf[i]) begin
            bad++;
            $display("FAIL classify[%0d]: valid=%b result=%h flags=%b expected 1/%h/%b",
                     i, out_valid, out_result, out_flags, vr[i], vf[i]);
         end
         $display("classify[%0d]: %h x %h (mul_o %h) -> %h flags %b", i, va[i], vb[i], vm[i], out_result, out_flags);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         total++;
         if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL classify_drain[%0d]: out_valid=%b expected 0", i, out_valid);
         end
      end
   endtask

   // ---------------------------------------------------------------
   task automatic test_backpressure();
      @(negedge clk);
      out_ready = 1'b0;
      drive_tag(16);                     // accepted at the next rising edge, count becomes 1
      @(negedge clk);
      drive_tag(17);                     // accepted, count becomes 2
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_ready_after_1: in_ready=%b expected 1", in_ready);
      end
      @(negedge clk);
      drive_tag(18);                     // offered while full
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("FAIL bp_ready_after_2: in_ready=%b expected 0", in_ready);
      end
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || out_result !== tag(16)) begin
         bad++;
         $display("FAIL bp_hold: in_ready=%b result=%h expected 0/%h", in_ready, out_result, tag(16));
      end
      $display("backpressure: full, head=%h", out_result);
      out_ready = 1'b1;                  // pop tag16; push is still blocked this edge
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || out_result !== tag(17)) begin
         bad++;
         $display("FAIL bp_first_pop: in_ready=%b result=%h expected 1/%h", in_ready, out_result, tag(17));
      end
      $display("backpressure: after first pop, head=%h", out_result);
      @(negedge clk);                    // pop tag17 and push tag18 at the same edge
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_result !== tag(18)) begin
         bad++;
         $display("FAIL bp_third: valid=%b result=%h expected 1/%h", out_valid, out_result, tag(18));
      end
      $display("backpressure: third pair at head=%h", out_result);
      @(negedge clk);
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_drain: out_valid=%b expected 0", out_valid);
      end
   endtask

   // ---------------------------------------------------------------
   task automatic test_back_to_back();
      @(negedge clk);
      out_ready = 1'b0;
      drive_tag(32);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_result !== tag(31 + i)) begin
            bad++;
            $display("FAIL b2b[%0d]: valid=%b in_ready=%b result=%h expected 1/1/%h",
                     i, out_valid, in_ready, out_result, tag(31 + i));
         end
         $display("b2b[%0d]: head=%h", i, out_result);
         out_ready = 1'b1;
         drive_tag(32 + i);
      end
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_result !== tag(42)) begin
         bad++;
         $display("FAIL b2b_last: valid=%b result=%h expected 1/%h", out_valid, out_result, tag(42));
      end
      @(negedge clk);
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL b2b_drain: out_valid=%b expected 0", out_valid);
      end
   endtask

   // ---------------------------------------------------------------
   task automatic test_reset_midstream();
      @(negedge clk);
      out_ready = 1'b0;
      drive_tag(64);
      @(negedge clk);
      drive_tag(65);
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL mid_full: in_ready=%b out_valid=%b expected 0/1", in_ready, out_valid);
      end
      #2 rst = 1'b1;                     // no clock edge before the check below
      #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'h0 || out_flags !== 4'h0) begin
         bad++;
         $display("FAIL mid_async_reset: valid=%b in_ready=%b result=%h flags=%b expected 0/1/00000000/0000",
                  out_valid, in_ready, out_result, out_flags);
      end
      $display("reset mid-stream: valid=%b in_ready=%b", out_valid, in_ready);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL mid_no_stale: out_valid=%b expected 0", out_valid);
      end
      drive_tag(80);
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_result !== tag(80)) begin
         bad++;
         $display("FAIL mid_fresh: valid=%b result=%h expected 1/%h", out_valid, out_result, tag(80));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL mid_fresh_only: out_valid=%b expected 0", out_valid);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_classify();
      test_backpressure();
      test_back_to_back();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
